// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM connection.
// slave = arbiter side, master = requesters/RAM side.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic [1:0]            owner;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_addr, ram_din, ram_we,
    input  ram_dout,
    output owner
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_addr, ram_din, ram_we,
    output ram_dout,
    input  owner
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM with 1-cycle read latency.
// Bounded bursts per owner; IDLE contention favours the port that did not own last.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15,
  parameter int BURST_LEN  = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int             CNT_W   = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic [CNT_W-1:0]      w_burst_cnt_nxt;
  logic                  r_last_b;
  logic                  w_last_b_nxt;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic                  w_a_gnt;
  logic                  w_b_gnt;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_din;

  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!rst) begin
      if (bus.a_req && !bus.b_req) begin
        w_a_gnt = 1'b1;
      end else if (bus.b_req && !bus.a_req) begin
        w_b_gnt = 1'b1;
      end else if (bus.a_req && bus.b_req) begin
        case (r_state)
          OWN_A: begin
            w_a_gnt = (r_burst_cnt < CNT_MAX);
            w_b_gnt = !(r_burst_cnt < CNT_MAX);
          end
          OWN_B: begin
            w_b_gnt = (r_burst_cnt < CNT_MAX);
            w_a_gnt = !(r_burst_cnt < CNT_MAX);
          end
          default: begin
            w_a_gnt = r_last_b;
            w_b_gnt = !r_last_b;
          end
        endcase
      end
    end
  end

  // Counter saturates so a lone requester never pushes it past BURST_LEN.
  always_comb begin
    w_state_nxt     = IDLE;
    w_burst_cnt_nxt = '0;
    w_last_b_nxt    = r_last_b;
    if (w_a_gnt) begin
      w_state_nxt = OWN_A;
      if (r_state == OWN_A) begin
        w_burst_cnt_nxt = (r_burst_cnt < CNT_MAX) ? r_burst_cnt + CNT_W'(1) : r_burst_cnt;
      end else begin
        w_burst_cnt_nxt = CNT_W'(1);
        w_last_b_nxt    = 1'b0;
      end
    end else if (w_b_gnt) begin
      w_state_nxt = OWN_B;
      if (r_state == OWN_B) begin
        w_burst_cnt_nxt = (r_burst_cnt < CNT_MAX) ? r_burst_cnt + CNT_W'(1) : r_burst_cnt;
      end else begin
        w_burst_cnt_nxt = CNT_W'(1);
        w_last_b_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_last_b    <= 1'b1;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_last_b    <= w_last_b_nxt;
      r_a_rvalid  <= w_a_gnt & ~bus.a_we;
      r_b_rvalid  <= w_b_gnt & ~bus.b_we;
    end
  end

  always_comb begin
    w_ram_addr = w_b_gnt ? bus.b_addr  : bus.a_addr;
    w_ram_din  = w_b_gnt ? bus.b_wdata : bus.a_wdata;
  end

  assign bus.a_gnt    = w_a_gnt;
  assign bus.b_gnt    = w_b_gnt;
  assign bus.ram_addr = w_ram_addr;
  assign bus.ram_din  = w_ram_din;
  assign bus.ram_we   = (w_a_gnt & bus.a_we) | (w_b_gnt & bus.b_we);
  // Masking with rst drops the rvalid of a read granted just before reset.
  assign bus.a_rvalid = r_a_rvalid & ~rst;
  assign bus.b_rvalid = r_b_rvalid & ~rst;
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;
  assign bus.owner    = r_state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rules, shadow memory, expected read returns).
module tb_ram_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst;
  logic ram_fill;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  function automatic logic [DW-1:0] pat(input int a);
    return DW'(a * 37) ^ DW'(16'hC3A5);
  endfunction

  // Environment RAM: registered read, write-after-read ordering.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
    end else begin
      bus.ram_dout <= mem[bus.ram_addr];
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    end
  end
  assign bus1.ram_dout = '0;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int            m_own;   // 0 none, 1 A, 2 B
  int            m_cnt;
  int            m_last;  // 1 A, 2 B
  bit            m_rva, m_rvb;
  logic [DW-1:0] m_rda, m_rdb;
  logic [DW-1:0] shadow [int];
  int            wait_a, wait_b;
  int            last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction

  function automatic int mgrant(input bit ar, input bit br);
    if (ar && !br) return 1;
    if (br && !ar) return 2;
    if (!ar && !br) return 0;
    if (m_own == 0) return (m_last == 2) ? 1 : 2;
    if (m_cnt < BL) return m_own;
    return 3 - m_own;
  endfunction

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 2;
    m_rva = 1'b0; m_rvb = 1'b0;
    wait_a = 0; wait_b = 0;
  endtask

  task automatic step();
    int g;
    @(negedge clk);
    g = rst ? 0 : mgrant(bus.a_req, bus.b_req);
    chk("a_gnt", 32'(bus.a_gnt), 32'(g == 1));
    chk("b_gnt", 32'(bus.b_gnt), 32'(g == 2));
    chk("ram_we", 32'(bus.ram_we), 32'((g == 1 && bus.a_we) || (g == 2 && bus.b_we)));
    chk("ram_addr", 32'(bus.ram_addr), 32'((g == 2) ? bus.b_addr : bus.a_addr));
    chk("ram_din", 32'(bus.ram_din), 32'((g == 2) ? bus.b_wdata : bus.a_wdata));
    chk("owner", 32'(bus.owner), 32'(m_own));
    chk("a_rvalid", 32'(bus.a_rvalid), 32'(m_rva && !rst));
    chk("b_rvalid", 32'(bus.b_rvalid), 32'(m_rvb && !rst));
    if (m_rva && !rst) chk("a_rdata", 32'(bus.a_rdata), 32'(m_rda));
    if (m_rvb && !rst) chk("b_rdata", 32'(bus.b_rdata), 32'(m_rdb));
    chk("a_rdata_bus", 32'(bus.a_rdata), 32'(bus.ram_dout));
    chk("b_rdata_bus", 32'(bus.b_rdata), 32'(bus.ram_dout));
    if (!rst && bus.a_req && !bus.a_gnt) begin
      wait_a++;
      chk("a_wait_bound", 32'(wait_a <= BL), 32'd1);
    end else wait_a = 0;
    if (!rst && bus.b_req && !bus.b_gnt) begin
      wait_b++;
      chk("b_wait_bound", 32'(wait_b <= BL), 32'd1);
    end else wait_b = 0;
    @(posedge clk);
    #1;
    last_g = g;
    if (rst) begin
      model_reset();
    end else begin
      m_rva = (g == 1) && !bus.a_we;
      m_rvb = (g == 2) && !bus.b_we;
      if (g == 1) begin
        if (bus.a_we) shadow[int'(bus.a_addr)] = bus.a_wdata;
        else m_rda = shadow_rd(int'(bus.a_addr));
      end
      if (g == 2) begin
        if (bus.b_we) shadow[int'(bus.b_addr)] = bus.b_wdata;
        else m_rdb = shadow_rd(int'(bus.b_addr));
      end
      if (g == 0) begin
        m_own = 0; m_cnt = 0;
      end else if (g == m_own) begin
        if (m_cnt < BL) m_cnt++;
      end else begin
        m_own = g; m_cnt = 1; m_last = g;
      end
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] lo;
    lo = AW'($urandom_range(0, 15));
    return ($urandom_range(0, 3) == 0) ? (AW'(15'h7FF0) | lo) : lo;
  endfunction

  // Requesters keep req and fields until granted, then pick a new request.
  task automatic refresh_reqs(input int pct);
    if (!bus.a_req || last_g == 1) begin
      bus.a_req   = ($urandom_range(0, 99) < pct);
      bus.a_we    = 1'($urandom_range(0, 1));
      bus.a_addr  = rnd_addr();
      bus.a_wdata = DW'($urandom);
    end
    if (!bus.b_req || last_g == 2) begin
      bus.b_req   = ($urandom_range(0, 99) < pct);
      bus.b_we    = 1'($urandom_range(0, 1));
      bus.b_addr  = rnd_addr();
      bus.b_wdata = DW'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ram_fill = 1'b1; last_g = 0;
    m_rda = '0; m_rdb = '0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_addr = '0; bus1.a_wdata = '0;
    bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_addr = '0; bus1.b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    ram_fill = 1'b0;
    model_reset();

    // Requests during reset must not be granted
    bus.a_req = 1'b1; bus.b_req = 1'b1; bus.a_we = 1'b1; bus.b_we = 1'b1;
    step();
    rst = 1'b0;

    // Both read after reset: A first, then B
    bus.a_we = 1'b0; bus.a_addr = AW'(16'h0010);
    bus.b_we = 1'b0; bus.b_addr = AW'(16'h0020);
    step();
    bus.a_req = 1'b0;
    step();
    bus.b_req = 1'b0;
    step();
    step();

    // Continuous contention: bursts of BL
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    repeat (5 * BL) step();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    step();

    // Write then read back top address on port A
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = AW'(16'h7FFF); bus.a_wdata = DW'(16'h1234);
    step();
    bus.a_we = 1'b0;
    step();
    bus.a_req = 1'b0;
    step();
    step();

    // Only B: five reads back to back
    for (int i = 0; i < 5; i++) begin
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = AW'(16'h0100 + i);
      step();
    end
    bus.b_req = 1'b0;
    step();
    step();

    // Reset right after a B read grant
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = AW'(16'h0033);
    step();
    rst = 1'b1; bus.a_req = 1'b1;
    step();
    rst = 1'b0; bus.a_req = 1'b0; bus.b_req = 1'b0;
    step();
    step();

    // Random traffic with occasional reset
    for (int n = 0; n < 1500; n++) begin
      refresh_reqs(70);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    step();

    // BURST_LEN=1 instance: strict alternation, then A alone
    bus1.a_req = 1'b1; bus1.b_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bl1_alt_a", 32'(bus1.a_gnt), 32'(i % 2 == 0));
      chk("bl1_alt_b", 32'(bus1.b_gnt), 32'(i % 2 == 1));
      @(posedge clk);
      #1;
    end
    bus1.b_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bl1_a_only_a", 32'(bus1.a_gnt), 32'd1);
      chk("bl1_a_only_b", 32'(bus1.b_gnt), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 15, RAM address width.
- BURST_LEN, 8, maximum consecutive grants to one port while the other port waits; legal range 1..255.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A requests one RAM access this cycle.
- a_we  in  1  port A access is a write (1) or read (0).
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_gnt  out  1  port A access issued to RAM this cycle.
- a_rvalid  out  1  port A read data valid this cycle.
- a_rdata  out  DATA_WIDTH  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same widths and meanings as the port A signals, for port B.
- ram_addr  out  ADDR_WIDTH  to the RAM addr input.
- ram_din  out  DATA_WIDTH  to the RAM din input.
- ram_we  out  1  to the RAM write-enable input.
- ram_dout  in  DATA_WIDTH  registered RAM output, valid one cycle after its address.
- owner  out  2  current state: 00 IDLE, 01 OWN_A, 10 OWN_B.

Function
REQ-003 Each cycle the arbiter SHALL issue at most one access to the single-port RAM.
REQ-004 a_gnt and b_gnt SHALL be combinational from the requests and the registered state, and SHALL never both be 1.
REQ-005 A granted request SHALL count as accepted in that cycle. The requester holds req and its fields until it sees gnt=1.
REQ-006 Grant rule, if only one port requests: that port SHALL be granted.
REQ-007 Grant rule, if both ports request:
- State OWN_X with burst_cnt < BURST_LEN: grant X.
- State OWN_X with burst_cnt == BURST_LEN: grant the other port.
- State IDLE: grant the port that is not last_owner.
REQ-008 With no request, no grant SHALL be issued. ram_we SHALL be 0, and ram_addr/ram_din SHALL hold the port A fields.
REQ-009 When a port is granted, ram_addr, ram_din and ram_we SHALL equal that port's addr, wdata and we in the same cycle.
REQ-010 State update on each edge:
- Granted port equals current owner: burst_cnt increments.
- Granted port differs from owner: state becomes OWN_that port, burst_cnt=1, last_owner=that port.
- No grant: state becomes IDLE, burst_cnt=0, last_owner unchanged.
REQ-011 burst_cnt SHALL be wide enough to hold BURST_LEN and SHALL never exceed it.
REQ-012 A read granted in cycle N SHALL assert that port's rvalid in cycle N+1 only. rdata SHALL equal ram_dout in that cycle. Read latency is 1.
REQ-013 rvalid SHALL be a registered per-port flag, set from gnt & ~we of that port.
REQ-014 a_rdata and b_rdata SHALL both be driven from ram_dout at all times. Consumers qualify the data with rvalid.
REQ-015 Writes SHALL produce no rvalid.
REQ-016 A read to an address written in the previous cycle SHALL return the new data.
REQ-017 A read and write to the same address cannot be issued in the same cycle; no special handling is needed.
REQ-018 With BURST_LEN=1 and both ports requesting continuously, grants SHALL strictly alternate.
REQ-019 A waiting port SHALL be granted within BURST_LEN+1 cycles of raising req, provided the owner holds req.

Reset
REQ-020 While rst=1 on an edge, the arbiter SHALL set:
- state=IDLE, owner=00.
- burst_cnt=0, last_owner=B, so A wins the first contention.
- a_rvalid=0 and b_rvalid=0.
REQ-021 While rst=1, a_gnt, b_gnt and ram_we SHALL be forced to 0.
REQ-022 A read issued in the cycle before reset SHALL have its rvalid suppressed; in-flight reads are discarded.

Verification
REQ-023 After reset, both ports request reads from 0x0010 (A) and 0x0020 (B) -> A granted first, a_rvalid the next cycle with mem[0x0010]; B granted in the following cycle.
REQ-024 BURST_LEN=8, both ports request continuously -> 8 A grants, 8 B grants, repeating; owner toggles 01/10; no cycle without a grant.
REQ-025 Port A writes 0x1234 to 0x7FFF, then reads 0x7FFF next cycle -> a_rvalid=1 with a_rdata=0x1234 one cycle after the read; b_rvalid stays 0 throughout.
REQ-026 Only B requests, 5 reads -> 5 consecutive b_gnt; b_rvalid pulses lag b_gnt by exactly one cycle; a_gnt stays 0.
REQ-027 rst asserted in the cycle after a B read grant -> b_rvalid=0 and owner=00 after the edge, and no grant during reset.
REQ-028 BURST_LEN=1, both ports request -> grants alternate A,B,A,B; when B drops req, A is granted every cycle.
